// File: rtl/fft_pkg.sv
// Shared FFT constants, twiddle index helper and sequencer state encoding.
package fft_pkg;

    localparam int unsigned LOG2N_DEF = 6;
    localparam int unsigned N = 1 << LOG2N_DEF;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Bit-reversed quarter index gives the radix-2^2 twiddle step k(q).
    function automatic logic [1:0] bitrev2(input logic [1:0] q);
        return {q[0], q[1]};
    endfunction

endpackage

// File: rtl/twid_delay.sv
// Synchronous-reset shift register of configurable width and depth (>= 1),
// used to align qualifiers and data with fixed-latency memories.
module twid_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/twiddle_addr_seq.sv
// Twiddle ROM address sequencer for the radix-2^2 SDF FFT.
// Define TWID_SEQ_IFFT_EN to add the 'inv' port (conjugate twiddles per frame).
module twiddle_addr_seq
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N   = LOG2N_DEF,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sop,
`ifdef TWID_SEQ_IFFT_EN
    input  logic             inv,
`endif
    output logic [LOG2N-1:0] rom_addr,
    output logic             addr_valid,
    output logic             tw_valid,
    output logic             tw_sop,
    output logic             frame_done,
    output logic             sop_err
);

    localparam logic [LOG2N-1:0] LAST = '1;

    state_t           state;
    logic [LOG2N-1:0] n;
    logic [LOG2N-1:0] acc;
    logic             addr_sop;

    logic             start;
    logic             accept;
    logic             inv_sel;
    logic [LOG2N-1:0] idx;
    logic [1:0]       k;
    logic [LOG2N-1:0] e;
    logic [LOG2N-1:0] e_out;

`ifdef TWID_SEQ_IFFT_EN
    logic inv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else if (start) begin
            inv_q <= inv;
        end
    end

    assign inv_sel = start ? inv : inv_q;
`else
    assign inv_sel = 1'b0;
`endif

    // acc carries the previous exponent; e = r*k is built by repeated addition.
    always_comb begin
        start  = in_valid & in_sop;
        accept = in_valid & (in_sop | (state == RUN));
        idx    = start ? '0 : n;
        k      = bitrev2(idx[LOG2N-1 -: 2]);
        e      = '0;
        if (idx[LOG2N-3:0] != '0) begin
            e = acc + {{(LOG2N-2){1'b0}}, k};
        end
        e_out  = inv_sel ? (-e) : e;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            n          <= '0;
            acc        <= '0;
            rom_addr   <= '0;
            addr_valid <= 1'b0;
            addr_sop   <= 1'b0;
            frame_done <= 1'b0;
            sop_err    <= 1'b0;
        end else begin
            addr_valid <= accept;
            addr_sop   <= accept & start;
            frame_done <= accept && (idx == LAST);
            if (accept) begin
                rom_addr <= e_out;
                acc      <= e;
                n        <= idx + 1'b1;
                state    <= (idx == LAST) ? IDLE : RUN;
                if ((state == RUN) && in_sop && (n != '0)) begin
                    sop_err <= 1'b1;
                end
            end
        end
    end

    twid_delay #(
        .WIDTH(2),
        .DEPTH(ROM_LAT)
    ) u_delay (
        .clk(clk),
        .rst(rst),
        .d  ({addr_valid, addr_sop}),
        .q  ({tw_valid, tw_sop})
    );

endmodule

// File: tb/tb_twiddle_addr_seq.sv
// Scoreboard bench for twiddle_addr_seq: driver queues expected responses,
// negedge monitors pop and compare whenever addr_valid / tw_valid appear.
module tb_twiddle_addr_seq;

    localparam int unsigned LOG2N   = 6;
    localparam int unsigned N       = 64;
    localparam int unsigned ROM_LAT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_sop;
    logic [5:0] rom_addr;
    logic       addr_valid;
    logic       tw_valid;
    logic       tw_sop;
    logic       frame_done;
    logic       sop_err;
`ifdef TWID_SEQ_IFFT_EN
    logic       inv;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    bit inv_frame = 1'b0;

    typedef struct {
        int         cyc;
        logic [5:0] addr;
        bit         done;
    } a_t;

    typedef struct {
        int cyc;
        bit sop;
    } t_t;

    a_t aq[$];
    t_t tq[$];
    a_t ma;
    t_t mt;

    twiddle_addr_seq #(
        .LOG2N  (LOG2N),
        .ROM_LAT(ROM_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
`ifdef TWID_SEQ_IFFT_EN
        .inv       (inv),
`endif
        .rom_addr  (rom_addr),
        .addr_valid(addr_valid),
        .tw_valid  (tw_valid),
        .tw_sop    (tw_sop),
        .frame_done(frame_done),
        .sop_err   (sop_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Exponent table written as r*k per quarter, conjugated when iv is set.
    function automatic logic [5:0] exp_addr(input int idx, input bit iv);
        int q;
        int r;
        int e;
        q = idx / 16;
        r = idx % 16;
        case (q)
            0:       e = 0;
            1:       e = 2 * r;
            2:       e = r;
            default: e = 3 * r;
        endcase
        if (iv) e = (64 - e) % 64;
        return e[5:0];
    endfunction

    task automatic send(input bit v, input bit sop, input bit acc, input int idx, input bit iv);
        a_t a;
        t_t t;
        in_valid = v;
        in_sop   = sop;
`ifdef TWID_SEQ_IFFT_EN
        inv = iv;
        if (acc && sop) inv_frame = iv;
`endif
        if (acc) begin
            a.cyc  = cyc + 1;
            a.addr = exp_addr(idx, inv_frame);
            a.done = (idx == N - 1);
            aq.push_back(a);
            t.cyc  = cyc + 1 + ROM_LAT;
            t.sop  = sop;
            tq.push_back(t);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int c);
        repeat (c) send(1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (addr_valid === 1'b1) begin
                if (aq.size() == 0) begin
                    chk("addr_valid_unexpected", 1, 0);
                end else begin
                    ma = aq.pop_front();
                    chk("addr_cycle", cyc, ma.cyc);
                    chk("rom_addr", rom_addr, ma.addr);
                    chk("frame_done", frame_done, ma.done);
                end
            end else begin
                chk("frame_done_without_valid", frame_done, 0);
            end
            if (tw_valid === 1'b1) begin
                if (tq.size() == 0) begin
                    chk("tw_valid_unexpected", 1, 0);
                end else begin
                    mt = tq.pop_front();
                    chk("tw_cycle", cyc, mt.cyc);
                    chk("tw_sop", tw_sop, mt.sop);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
`ifdef TWID_SEQ_IFFT_EN
        inv = 1'b0;
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_addr_valid", addr_valid, 0);
        chk("rst_tw_valid", tw_valid, 0);
        chk("rst_tw_sop", tw_sop, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_sop_err", sop_err, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // single continuous frame
        for (int i = 0; i < N; i++) send(1'b1, i == 0, 1'b1, i, 1'b0);
        idle(3);

        // in_valid toggled every cycle
        for (int i = 0; i < N; i++) begin
            send(1'b1, i == 0, 1'b1, i, 1'b0);
            send(1'b0, 1'b0, 1'b0, 0, 1'b0);
        end
        idle(3);

        // two frames back-to-back
        for (int i = 0; i < 2 * N; i++) send(1'b1, (i % N) == 0, 1'b1, i % N, 1'b0);
        idle(3);

        // samples without sop in IDLE are ignored
        repeat (3) send(1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(1);
        chk("sop_err_clear", sop_err, 0);

        // sop at n=10 aborts the frame and restarts at index 0
        for (int i = 0; i < 10; i++) send(1'b1, i == 0, 1'b1, i, 1'b0);
        send(1'b1, 1'b1, 1'b1, 0, 1'b0);
        chk("sop_err_set", sop_err, 1);
        for (int i = 1; i < N; i++) send(1'b1, 1'b0, 1'b1, i, 1'b0);
        idle(3);
        chk("sop_err_sticky", sop_err, 1);

        // reset while running at n=20
        for (int i = 0; i < 20; i++) send(1'b1, i == 0, 1'b1, i, 1'b0);
        idle(1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sop   = 1'b0;
        @(posedge clk); #1;
        chk("midrst_addr_valid", addr_valid, 0);
        chk("midrst_tw_valid", tw_valid, 0);
        chk("midrst_rom_addr", rom_addr, 0);
        chk("midrst_sop_err", sop_err, 0);
        rst = 1'b0;
        repeat (2) send(1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(3);
        chk("post_rst_rom_addr_hold", rom_addr, 0);

`ifdef TWID_SEQ_IFFT_EN
        // conjugate frame; inv dropped after sop must not matter
        for (int i = 0; i < N; i++) send(1'b1, i == 0, 1'b1, i, i == 0);
        idle(3);
        // forward frame afterwards
        for (int i = 0; i < N; i++) send(1'b1, i == 0, 1'b1, i, 1'b0);
        idle(3);
`endif

        chk("addr_queue_drained", aq.size(), 0);
        chk("tw_queue_drained", tq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/twiddle_addr_seq.md
Name: twiddle_addr_seq

Overview:
- Address sequencer for the 64-entry twiddle ROM (`twiddlefactors`: clk, addr[5:0], signed 8-bit twiddle_re/twiddle_im) in the radix-2² SDF FFT.
- Sits between stage pair 1 and the complex multiplier.
- Tracks sample index within a frame and generates the ROM address (twiddle exponent e, W_N^e) per accepted sample.
- Re-times valid/sop so they line up with the ROM data.

Parameters:
- LOG2N, 6: log2 of FFT length N; must be even, ≥4; ROM depth N.
- ROM_LAT, 1: ROM read latency in cycles; ≥1.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: sample accepted this cycle.
- in_sop, in, 1: first sample of frame; qualified by in_valid.
- rom_addr, out, LOG2N: address to twiddle ROM (exponent e).
- addr_valid, out, 1: rom_addr corresponds to an accepted sample.
- tw_valid, out, 1: addr_valid delayed ROM_LAT; qualifies ROM output.
- tw_sop, out, 1: sop aligned with tw_valid.
- frame_done, out, 1: one-cycle pulse with the addr_valid of sample N-1.
- sop_err, out, 1: sticky; sop seen mid-frame; cleared only by rst.

Behaviour:
- Reset: every output is 0. State is IDLE. Counters are 0. The delay line is flushed.
- State IDLE:
  - in_valid & in_sop → RUN; this sample is index n=0.
  - in_valid without sop → ignored; addr_valid stays 0.
- State RUN:
  - Each in_valid advances n by 1. Cycles with in_valid=0 stall; all state is held.
  - After sample N-1 is accepted: if the same cycle carries no new sop, go to IDLE.
  - Back-to-back frames: sop accepted in the cycle right after sample N-1 continues without a gap. This is because IDLE accepts sop in that same cycle.
- Sop mid-frame (RUN, n≠0 expected): set sop_err. Restart at n=0. The truncated frame emits no frame_done.
- Index split: q = n[LOG2N-1:LOG2N-2] (quarter), r = n[LOG2N-3:0].
- Exponent: e = r·k(q), with k = bitrev2(q), i.e. q=0→0, 1→2, 2→1, 3→3.
  - Computed by an accumulator, no multiplier. acc is cleared at r=0 and incremented by k on each accepted sample.
  - Max e = 3·(N/4−1) < N, so no wrap for the forward transform.
  - Width is LOG2N bits.
- Latency:
  - rom_addr and addr_valid are registered, 1 cycle after the accepting edge.
  - tw_valid and tw_sop come ROM_LAT cycles after addr_valid.
  - rom_addr holds its last value when addr_valid=0.
- rst mid-frame: sequence aborts, delay line clears, IDLE next cycle.
- The sequencer does not generate any duplicate tw_valid for a single accepted sample.

Optional Feature:
- Macro: TWID_SEQ_IFFT_EN.
- Defined:
  - Adds input port `inv` (1 bit), sampled with the accepted sop and held for the whole frame.
  - When inv=1: rom_addr = (N − e) mod N, i.e. the conjugate twiddle. e=0 maps to 0.
- Undefined:
  - Port absent; forward exponents only.

Decomposition:
- Package fft_pkg holds:
  - LOG2N default.
  - N = 1<<LOG2N.
  - bitrev2 function.
  - State enum {IDLE, RUN}.
- Sub-module twid_delay holds the ROM_LAT-deep shift register for valid/sop. It is synchronous-reset and also reused for data alignment elsewhere.

Test Plan:
- Reset with in_valid=0 → all outputs 0. Assert rst during RUN at n=20 → next cycle IDLE, addr_valid=0, tw_valid=0 after ROM_LAT cycles.
- One frame, in_valid continuous, sop at n=0 →
  - rom_addr for n=0..15: all 0.
  - n=16..31: 0,2,…,30.
  - n=32..47: 0,1,…,15.
  - n=48..63: 0,3,…,45.
  - frame_done pulses with n=63.
  - tw_valid is addr_valid delayed 1.
- in_valid toggled 1/0 every cycle → same address sequence, with addr_valid gaps matching the input gaps.
- Two frames back-to-back (sop in the cycle after n=63) → no bubble; second frame starts rom_addr=0; two frame_done pulses.
- in_valid without sop in IDLE → addr_valid=0. Then sop at n=10 of a running frame → sop_err=1, next rom_addr=0, no frame_done for the aborted frame.
- TWID_SEQ_IFFT_EN, inv=1 → n=49 gives rom_addr=61 (64−3); n=0 gives 0; n=33 gives 63.
